idu_scoreboard: RTL
===================

Name: idu_scoreboard

Overview:
- Issue controller between the decode stage and the execute stage.
- Tracks in-flight GPR writes and CSR writes, and stalls the decode-to-execute handshake on RAW/WAW hazards or inflight-limit overflow.
- Serializes system instructions (csr*, ecall, mret) and fence.i by draining the pipe before issue and holding issue until they retire.
- Sits on the valid/ready path from decode to execute; the writeback stage pulses retirement back into it.

Parameters:
- REG_ADDRW, 5, GPR index width.
- CNT_W, 2, width of each per-register pending counter; saturation value is 2^CNT_W-1.
- INFL_W, 3, width of the total-inflight counter.
- MAX_INFLIGHT, 4, maximum number of issued but unretired instructions; must be <= 2^INFL_W-1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pre_valid  in  1  decoded instruction valid
- o_pre_ready  out  1  decode may advance
- o_post_valid  out  1  instruction issued to execute
- i_post_ready  in  1  execute accepts
- i_rs1id  in  REG_ADDRW  source 1 index
- i_rs2id  in  REG_ADDRW  source 2 index
- i_rdid  in  REG_ADDRW  destination index
- i_rdwen  in  1  destination write enable
- i_csrsren  in  1  instruction reads a CSR
- i_csrdwen  in  1  instruction writes a CSR
- i_sysins  in  1  system-opcode instruction
- i_fence_i  in  1  fence.i
- i_wb_valid  in  1  one instruction retires this cycle
- i_wb_rdid  in  REG_ADDRW  retiring destination
- i_wb_rdwen  in  1  retiring instruction wrote a GPR
- i_wb_csrdwen  in  1  retiring instruction wrote a CSR
- i_flush  in  1  discard all in-flight tracking (trap or redirect)
- o_inflight  out  INFL_W  current inflight count
- o_busy  out  1  state is not RUN, or inflight != 0
- o_sb_err  out  1  sticky retirement-underflow error

Behaviour:
State and reset:
- State: cnt[1..31] (CNT_W each; x0 never tracked), csr_cnt (CNT_W), infl (INFL_W), fsm in {RUN, DRAIN, SERIAL}.
- Reset (asynchronous, while i_rst_n=0): all counters 0, fsm=RUN, o_sb_err=0.
- While reset is asserted, o_pre_ready=0 and o_post_valid=0.

Hazard and stall:
- serial = i_sysins | i_fence_i.
- haz is the OR of:
  - rs1id!=0 & cnt[rs1id]!=0
  - rs2id!=0 & cnt[rs2id]!=0
  - i_rdwen & rdid!=0 & cnt[rdid] saturated
  - i_csrsren & csr_cnt!=0
  - i_csrdwen & csr_cnt saturated
  - infl==MAX_INFLIGHT
- stall = i_flush | haz | (fsm!=RUN) | (serial & infl!=0).
- o_post_valid = i_pre_valid & ~stall. o_pre_ready = i_post_ready & ~stall.
- Both are combinational; there is no added latency.
- issue = o_post_valid & i_post_ready.

Counter update (per cycle):
- Hazard checks use registered counters only. A retirement in cycle N unblocks a dependent instruction in cycle N+1, never in N.
- On issue: infl+1. If i_rdwen & rdid!=0, cnt[rdid]+1. If i_csrdwen, csr_cnt+1.
- On i_wb_valid: infl-1. If i_wb_rdwen & wb_rdid!=0, cnt[wb_rdid]-1. If i_wb_csrdwen, csr_cnt-1.
- Simultaneous issue and retire to the same counter: net unchanged.
- Every issued instruction, including serial and no-rd instructions, retires with exactly one i_wb_valid pulse.
- Underflow (decrement of a zero counter): the counter holds 0 and o_sb_err sets. o_sb_err clears only on reset.

FSM:
- RUN -> DRAIN when i_pre_valid & serial & infl!=0.
- RUN -> SERIAL on issue of a serial instruction.
- DRAIN -> RUN when infl==0. The serial instruction issues from RUN on a later cycle.
- SERIAL -> RUN on the cycle i_wb_valid brings infl to 0. The next instruction may issue the following cycle.
- i_flush (synchronous, highest priority): all counters 0, fsm=RUN, no issue that cycle. A concurrent i_wb_valid is ignored.
- o_inflight = infl. o_busy = (fsm!=RUN) | (infl!=0).

Test Plan:
- Reset release, then issue add x5 with post_ready=1 -> o_post_valid=1 same cycle, o_inflight=1, cnt[5]=1.
- Issue wr x5, then next instr reads rs1=x5 -> stalled (o_pre_ready=0). wb x5 in cycle N -> reader issues in cycle N+1, o_inflight back to 1.
- Read rs1=x0 while x0 write in flight -> no stall. Four independent issues -> o_inflight=4, 5th stalled until any wb.
- csrrw with infl=2 -> DRAIN, stall. After 2 wb -> issue, SERIAL. Next add stalls until csrrw wb, then issues the following cycle.
- i_flush with infl=3 plus concurrent wb -> o_inflight=0, fsm=RUN, no issue that cycle. Subsequent wb pulse -> o_sb_err=1, o_inflight stays 0.
- Same-cycle issue of wr x7 and wb of x7 with cnt[7]=1 -> cnt[7] stays 1, o_inflight unchanged.

Source files
------------

// File: rtl/idu_scoreboard.sv
// Issue controller between decode and execute: tracks in-flight GPR/CSR writes,
// stalls on RAW/WAW hazards or inflight overflow, and serializes system/fence.i.
module idu_scoreboard #(
   parameter int REG_ADDRW    = 5,
   parameter int CNT_W        = 2,
   parameter int INFL_W       = 3,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_pre_valid,
   output logic                 o_pre_ready,
   output logic                 o_post_valid,
   input  logic                 i_post_ready,
   input  logic [REG_ADDRW-1:0] i_rs1id,
   input  logic [REG_ADDRW-1:0] i_rs2id,
   input  logic [REG_ADDRW-1:0] i_rdid,
   input  logic                 i_rdwen,
   input  logic                 i_csrsren,
   input  logic                 i_csrdwen,
   input  logic                 i_sysins,
   input  logic                 i_fence_i,
   input  logic                 i_wb_valid,
   input  logic [REG_ADDRW-1:0] i_wb_rdid,
   input  logic                 i_wb_rdwen,
   input  logic                 i_wb_csrdwen,
   input  logic                 i_flush,
   output logic [INFL_W-1:0]    o_inflight,
   output logic                 o_busy,
   output logic                 o_sb_err
);

   // Handshake: an instruction moves decode->execute on a cycle where
   // o_post_valid & i_post_ready; o_pre_ready mirrors i_post_ready unless stalled.

   localparam int                NREG     = 1 << REG_ADDRW;
   localparam logic [CNT_W-1:0]  CNT_SAT  = '1;
   localparam logic [INFL_W-1:0] INFL_MAX = INFL_W'(MAX_INFLIGHT);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SERIAL = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q [NREG];
   logic [CNT_W-1:0]   cnt_d [NREG];
   logic [CNT_W-1:0]   csr_cnt_q, csr_cnt_d;
   logic [INFL_W-1:0]  infl_q, infl_d;
   logic               sb_err_q, sb_err_d;

   logic serial;
   logic haz;
   logic stall;
   logic issue;

   always_comb begin
      serial = i_sysins | i_fence_i;
      haz    = ((i_rs1id != '0) && (cnt_q[i_rs1id] != '0))
             | ((i_rs2id != '0) && (cnt_q[i_rs2id] != '0))
             | (i_rdwen && (i_rdid != '0) && (cnt_q[i_rdid] == CNT_SAT))
             | (i_csrsren && (csr_cnt_q != '0))
             | (i_csrdwen && (csr_cnt_q == CNT_SAT))
             | (infl_q == INFL_MAX);
      stall  = i_flush | haz | (state_q != ST_RUN) | (serial & (infl_q != '0));
      o_post_valid = i_rst_n & i_pre_valid & ~stall;
      o_pre_ready  = i_rst_n & i_post_ready & ~stall;
      issue        = o_post_valid & i_post_ready;
   end

   // A decrement of an empty counter holds it at zero and raises the sticky error.
   always_comb begin
      logic inc;
      logic dec;
      sb_err_d  = sb_err_q;
      csr_cnt_d = csr_cnt_q;
      infl_d    = infl_q;
      inc       = 1'b0;
      dec       = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = cnt_q[r];
      end
      if (i_flush) begin
         for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = '0;
         end
         csr_cnt_d = '0;
         infl_d    = '0;
      end else begin
         for (int r = 1; r < NREG; r++) begin
            inc = issue & i_rdwen & (i_rdid == REG_ADDRW'(r));
            dec = i_wb_valid & i_wb_rdwen & (i_wb_rdid == REG_ADDRW'(r));
            if (inc && !dec) begin
               cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec && !inc) begin
               if (cnt_q[r] == '0) sb_err_d = 1'b1;
               else                cnt_d[r] = cnt_q[r] - 1'b1;
            end
         end
         inc = issue & i_csrdwen;
         dec = i_wb_valid & i_wb_csrdwen;
         if (inc && !dec) begin
            csr_cnt_d = csr_cnt_q + 1'b1;
         end else if (dec && !inc) begin
            if (csr_cnt_q == '0) sb_err_d  = 1'b1;
            else                 csr_cnt_d = csr_cnt_q - 1'b1;
         end
         inc = issue;
         dec = i_wb_valid;
         if (inc && !dec) begin
            infl_d = infl_q + 1'b1;
         end else if (dec && !inc) begin
            if (infl_q == '0) sb_err_d = 1'b1;
            else              infl_d   = infl_q - 1'b1;
         end
      end
      cnt_d[0] = '0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (issue && serial)                                state_d = ST_SERIAL;
            else if (i_pre_valid && serial && (infl_q != '0)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (infl_q == '0) state_d = ST_RUN;
         end
         ST_SERIAL: begin
            if (i_wb_valid && (infl_q <= INFL_W'(1))) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
      if (i_flush) state_d = ST_RUN;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_RUN;
         csr_cnt_q <= '0;
         infl_q    <= '0;
         sb_err_q  <= 1'b0;
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         state_q   <= state_d;
         csr_cnt_q <= csr_cnt_d;
         infl_q    <= infl_d;
         sb_err_q  <= sb_err_d;
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   assign o_inflight = infl_q;
   assign o_busy     = (state_q != ST_RUN) | (infl_q != '0);
   assign o_sb_err   = sb_err_q;

endmodule
